// File: rtl/main_memory_pkg.sv
// Shared constants and FSM state encoding for the line-granular main memory.
package main_memory_pkg;
  localparam int MEM_LINES_DFLT = 1024;
  localparam int MEM_LATENCY    = 5;

  typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_RESP} mem_state_e;
endpackage

// File: rtl/main_memory_if.sv
// Cache-side memory request/response bus; master = requester (arbiter), slave = memory.
interface main_memory_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
);
  logic                  req_valid;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LINE_WIDTH-1:0] req_data;
  logic                  resp_valid;
  logic [LINE_WIDTH-1:0] resp_data;
  logic [ADDR_WIDTH-1:0] resp_addr;
  logic                  busy;

  modport master (output req_valid, req_write, req_addr, req_data,
                  input  resp_valid, resp_data, resp_addr, busy);
  modport slave  (input  req_valid, req_write, req_addr, req_data,
                  output resp_valid, resp_data, resp_addr, busy);
endinterface

// File: rtl/main_memory_line_array.sv
// Single-port line storage with registered read port; contents are never reset.
module mem_line_array #(
  parameter int MEM_LINES  = 1024,
  parameter int LINE_WIDTH = 128,
  parameter int IDX_WIDTH  = $clog2(MEM_LINES)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [IDX_WIDTH-1:0]  i_idx,
  input  logic [LINE_WIDTH-1:0] i_wdata,
  output logic [LINE_WIDTH-1:0] o_rdata
);
  logic [LINE_WIDTH-1:0] r_mem [MEM_LINES];
  logic [LINE_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
    if (i_re) r_rdata      <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/main_memory.sv
// Main-memory responder: one line read/write in flight, answered after LATENCY cycles.
// Optional MEM_FAST_WRITE_EN: writes skip the wait and respond in cycle 1.
module main_memory
  import main_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int MEM_LINES  = MEM_LINES_DFLT,
  parameter int LATENCY    = MEM_LATENCY
) (
  input  logic           clk,
  input  logic           reset,
  main_memory_if.slave   bus
);
  localparam int OFFSET_WIDTH = $clog2(LINE_WIDTH/8);
  localparam int IDX_WIDTH    = $clog2(MEM_LINES);
  localparam int LINE_AW      = ADDR_WIDTH - OFFSET_WIDTH;
  localparam int CNT_WIDTH    = $clog2(LATENCY + 1);

  mem_state_e            r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_write;
  logic [LINE_AW-1:0]    r_line;
  logic [LINE_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH-1:0] r_resp_addr;
  logic [LINE_WIDTH-1:0] r_resp_wdata;
  logic                  r_resp_rd;

  logic                  w_accept, w_enter_resp, w_cur_write;
  logic [LINE_AW-1:0]    w_cur_line;
  logic [LINE_WIDTH-1:0] w_cur_data, w_rdata;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      MEM_IDLE: if (bus.req_valid) begin
        w_accept    = 1'b1;
        w_state_nxt = (LATENCY == 1) ? MEM_RESP : MEM_WAIT;
`ifdef MEM_FAST_WRITE_EN
        if (bus.req_write) w_state_nxt = MEM_RESP;
`endif
      end
      MEM_WAIT: if (r_cnt == CNT_WIDTH'(1)) w_state_nxt = MEM_RESP;
      MEM_RESP: w_state_nxt = MEM_IDLE;
      default:  w_state_nxt = MEM_IDLE;
    endcase
    // On a direct IDLE->RESP hop the request is not latched yet, so take it from the bus.
    w_cur_write  = (r_state == MEM_IDLE) ? bus.req_write : r_write;
    w_cur_line   = (r_state == MEM_IDLE) ? bus.req_addr[ADDR_WIDTH-1:OFFSET_WIDTH] : r_line;
    w_cur_data   = (r_state == MEM_IDLE) ? bus.req_data : r_data;
    w_enter_resp = (w_state_nxt == MEM_RESP) && (r_state != MEM_RESP) && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= MEM_IDLE;
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_line       <= '0;
      r_data       <= '0;
      r_resp_addr  <= '0;
      r_resp_wdata <= '0;
      r_resp_rd    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_write <= bus.req_write;
        r_line  <= bus.req_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
        r_data  <= bus.req_data;
        r_cnt   <= CNT_WIDTH'(LATENCY - 1);
      end else if (r_state == MEM_WAIT) begin
        r_cnt <= r_cnt - CNT_WIDTH'(1);
      end
      if (w_enter_resp) begin
        r_resp_addr <= {w_cur_line, {OFFSET_WIDTH{1'b0}}};
        r_resp_rd   <= !w_cur_write;
        if (w_cur_write) r_resp_wdata <= w_cur_data;
      end
    end
  end

  mem_line_array #(
    .MEM_LINES  (MEM_LINES),
    .LINE_WIDTH (LINE_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_array (
    .clk     (clk),
    .i_we    (w_enter_resp && w_cur_write),
    .i_re    (w_enter_resp && !w_cur_write),
    .i_idx   (w_cur_line[IDX_WIDTH-1:0]),
    .i_wdata (w_cur_data),
    .o_rdata (w_rdata)
  );

  // Read data lives in the array's output register; write data in r_resp_wdata.
  assign bus.resp_valid = (r_state == MEM_RESP);
  assign bus.resp_addr  = r_resp_addr;
  assign bus.resp_data  = r_resp_rd ? w_rdata : r_resp_wdata;
  assign bus.busy       = (r_state != MEM_IDLE);
endmodule

// File: tb/tb_main_memory.sv
// Self-checking bench for main_memory: latency, aliasing, held requests, mid-op reset.
module tb_main_memory;
  localparam int LAT = 5;
`ifdef MEM_FAST_WRITE_EN
  localparam int LAT_W = 1;
`else
  localparam int LAT_W = LAT;
`endif

  typedef struct {
    logic [31:0]  a;
    logic [127:0] d;
    bit           chk;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  logic [127:0] model [int];

  main_memory_if #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) bus ();

  main_memory #(.ADDR_WIDTH(32), .LINE_WIDTH(128), .MEM_LINES(1024), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Record the expected response for a request and update the reference memory.
  task automatic push_exp(input logic w, input logic [31:0] a, input logic [127:0] d);
    exp_t e;
    int   idx;
    idx   = int'(a[13:4]);
    e.a   = {a[31:4], 4'h0};
    e.chk = 1'b1;
    if (w) begin
      model[idx] = d;
      e.d = d;
    end else if (model.exists(idx)) e.d = model[idx];
    else begin
      e.d = '0;
      e.chk = 1'b0;
    end
    sb.push_back(e);
  endtask

  // Issue one request, hold it until the response pulse, return latency and response.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [127:0] d,
                        output int lat, output logic [31:0] ra, output logic [127:0] rd);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_data = d;
    push_exp(w, a, d);
    lat = -1; ra = '0; rd = '0;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk); @(negedge clk);
      if (bus.resp_valid) begin
        lat = k; ra = bus.resp_addr; rd = bus.resp_data;
        break;
      end
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset;
    int bad;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL reset_idle: %0d cycles with resp_valid/busy set, need 0", bad); end
    n_tests++;
    if (bus.resp_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h need 0", bus.resp_addr); end
    n_tests++;
    if (bus.resp_data !== 128'h0) begin n_fail++; $display("FAIL reset_data: got %h need 0", bus.resp_data); end
  endtask

  task automatic test_write_read;
    int lat; logic [31:0] ra; logic [127:0] rd; exp_t e;
    logic [127:0] pat;
    pat = {16{8'hA5}};
    do_req(1'b1, 32'h0000_1040, pat, lat, ra, rd);
    e = sb.pop_front();
    n_tests++;
    if (lat !== LAT_W) begin n_fail++; $display("FAIL wr_latency: got %0d need %0d", lat, LAT_W); end
    n_tests++;
    if (ra !== 32'h0000_1040 || ra !== e.a) begin n_fail++; $display("FAIL wr_addr: got %h need %h", ra, e.a); end
    n_tests++;
    if (rd !== e.d) begin n_fail++; $display("FAIL wr_data: got %h need %h", rd, e.d); end
    @(posedge clk); @(negedge clk);
    n_tests++;
    if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_pulse_len: resp_valid %b need 0", bus.resp_valid); end
    n_tests++;
    if (bus.resp_addr !== 32'h0000_1040) begin n_fail++; $display("FAIL wr_addr_hold: got %h need 00001040", bus.resp_addr); end

    do_req(1'b0, 32'h0000_104C, '0, lat, ra, rd);
    e = sb.pop_front();
    n_tests++;
    if (lat !== LAT) begin n_fail++; $display("FAIL rd_latency: got %0d need %0d", lat, LAT); end
    n_tests++;
    if (ra !== 32'h0000_1040) begin n_fail++; $display("FAIL rd_addr: got %h need 00001040", ra); end
    n_tests++;
    if (rd !== pat || rd !== e.d) begin n_fail++; $display("FAIL rd_data: got %h need %h", rd, pat); end

    // last line of the array
    pat = {$urandom, $urandom, $urandom, $urandom};
    do_req(1'b1, 32'h0000_3FF0, pat, lat, ra, rd);
    e = sb.pop_front();
    do_req(1'b0, 32'h0000_3FF8, '0, lat, ra, rd);
    e = sb.pop_front();
    n_tests++;
    if (rd !== e.d || ra !== e.a) begin n_fail++; $display("FAIL top_line: got %h@%h need %h@%h", rd, ra, e.d, e.a); end
  endtask

  task automatic test_alias;
    int lat; logic [31:0] ra; logic [127:0] rd; exp_t e;
    logic [127:0] d1;
    d1 = 128'hD1D1_0001_2345_6789_ABCD_EF01_1357_9BDF;
    do_req(1'b1, 32'h0000_0010, d1, lat, ra, rd);
    e = sb.pop_front();
    do_req(1'b0, 32'h0000_4010, '0, lat, ra, rd);
    e = sb.pop_front();
    n_tests++;
    if (rd !== d1 || rd !== e.d) begin n_fail++; $display("FAIL alias_data: got %h need %h", rd, d1); end
    n_tests++;
    if (ra !== 32'h0000_4010) begin n_fail++; $display("FAIL alias_addr: got %h need 00004010", ra); end
  endtask

  task automatic test_back_to_back;
    int pulses[$]; logic [31:0] ras[$]; logic [127:0] rds[$];
    int lat; logic [31:0] ra; logic [127:0] rd; exp_t e;
    logic [127:0] d2, d3;
    d2 = {4{32'hD2D2_0102}};
    d3 = {4{32'hD3D3_0304}};
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h0000_0100; bus.req_data = d2;
    push_exp(1'b1, 32'h0000_0100, d2);
    for (int k = 1; k <= 2*LAT_W + 4; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 2) begin
        bus.req_addr = 32'h0000_0200; bus.req_data = d3;
        push_exp(1'b1, 32'h0000_0200, d3);
      end
      if (bus.resp_valid) begin
        pulses.push_back(k); ras.push_back(bus.resp_addr); rds.push_back(bus.resp_data);
        if (pulses.size() == 2) bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    n_tests++;
    if (pulses.size() != 2) begin n_fail++; $display("FAIL held_pulses: got %0d need 2", pulses.size()); end
    else begin
      n_tests++;
      if (pulses[0] != LAT_W || pulses[1] != 2*LAT_W + 1) begin
        n_fail++; $display("FAIL held_timing: got %0d,%0d need %0d,%0d", pulses[0], pulses[1], LAT_W, 2*LAT_W+1);
      end
      for (int i = 0; i < 2; i++) begin
        e = sb.pop_front();
        n_tests++;
        if (ras[i] !== e.a || rds[i] !== e.d) begin
          n_fail++; $display("FAIL held_resp%0d: got %h@%h need %h@%h", i, rds[i], ras[i], e.d, e.a);
        end
      end
    end
    sb.delete();
    do_req(1'b0, 32'h0000_0100, '0, lat, ra, rd);
    e = sb.pop_front();
    n_tests++;
    if (rd !== d2 || rd !== e.d) begin n_fail++; $display("FAIL held_rb_first: got %h need %h", rd, d2); end
    do_req(1'b0, 32'h0000_0200, '0, lat, ra, rd);
    e = sb.pop_front();
    n_tests++;
    if (rd !== d3 || rd !== e.d) begin n_fail++; $display("FAIL held_rb_second: got %h need %h", rd, d3); end
  endtask

  task automatic test_reset_mid;
    int lat, pulses, exp_pulses; logic [31:0] ra; logic [127:0] rd; exp_t e;
    logic [127:0] p, q;
    p = {4{32'h5050_AAAA}};
    q = {4{32'hC0DE_0BAD}};
    do_req(1'b1, 32'h0000_0020, p, lat, ra, rd);
    e = sb.pop_front();
    exp_pulses = (LAT_W <= 3) ? 1 : 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h0000_0020; bus.req_data = q;
    if (exp_pulses == 1) push_exp(1'b1, 32'h0000_0020, q);
    pulses = 0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); @(negedge clk);
      if (bus.resp_valid) begin pulses++; bus.req_valid = 1'b0; end
    end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0; bus.req_valid = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.resp_addr !== 32'h0) begin
      n_fail++; $display("FAIL midrst_state: busy %b addr %h need 0/0", bus.busy, bus.resp_addr);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.resp_valid) pulses++;
    end
    n_tests++;
    if (pulses != exp_pulses) begin n_fail++; $display("FAIL midrst_pulses: got %0d need %0d", pulses, exp_pulses); end
    sb.delete();
    do_req(1'b0, 32'h0000_0020, '0, lat, ra, rd);
    e = sb.pop_front();
    n_tests++;
    if (rd !== e.d || rd !== ((exp_pulses == 1) ? q : p)) begin
      n_fail++; $display("FAIL midrst_readback: got %h need %h", rd, e.d);
    end
    n_tests++;
    if (lat !== LAT) begin n_fail++; $display("FAIL midrst_rd_latency: got %0d need %0d", lat, LAT); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_data = '0;
    test_reset();
    test_write_read();
    test_alias();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, need completion");
    $fatal(1, "watchdog");
  end
endmodule
